mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width (even, >=4).
REQ-002 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request an operation; sampled only when busy=0.
REQ-005 SHALL have port op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port a  input  WIDTH  multiplicand / dividend (rs data).
REQ-007 SHALL have port b  input  WIDTH  multiplier / divisor (rt data).
REQ-008 SHALL have port hi_we, lo_we  input  1 each  MTHI / MTLO write enables.
REQ-009 SHALL have port wdata  input  WIDTH  MTHI/MTLO write data.
REQ-010 SHALL have port busy  output  1  operation in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse, HI/LO hold new result.
REQ-012 SHALL have port div_by_zero  output  1  set with done when a divide had b=0, cleared at next accepted start.
REQ-013 SHALL have ports hi, lo  output  WIDTH each  registered HI and LO.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIXUP; busy = (state != IDLE).
REQ-015 SHALL on edge with state IDLE and start=1: latch op, a, b (magnitudes for signed ops, operand signs stored), clear iteration counter, enter CALC.
REQ-016 SHALL in CALC perform one radix-2 step per cycle (shift-add multiply, restoring divide) for exactly WIDTH cycles, then enter FIXUP.
REQ-017 SHALL in FIXUP apply sign correction, write hi/lo, pulse done for the following cycle, return to IDLE.
REQ-018 SHALL have done high exactly WIDTH+2 edges after the accepting edge; busy high the WIDTH+1 cycles before that; a new start is accepted in the done cycle.
REQ-019 SHALL produce for multiply {hi,lo} = full 2*WIDTH-bit product, two's complement for MULT.
REQ-020 SHALL produce for divide lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
REQ-021 SHALL for b=0 divides (signed or unsigned) still take full latency, give lo=all ones, hi=a, div_by_zero=1.
REQ-022 SHALL for DIV of most-negative by -1 give lo=most-negative, hi=0, div_by_zero=0.
REQ-023 SHALL ignore start, hi_we, lo_we while busy=1 (no queuing).
REQ-024 SHALL when idle write wdata to hi/lo on hi_we/lo_we; if start is accepted on the same edge the write takes effect and is later overwritten by the result.
REQ-025 SHALL keep hi/lo stable, except for REQ-024 writes, from FIXUP until the next FIXUP.

Reset
REQ-026 SHALL on edge with RST=0 force IDLE, hi=0, lo=0, done=0, div_by_zero=0, counter=0, overriding all other inputs.
REQ-027 SHALL abort any in-flight operation on reset with no done pulse and no partial HI/LO update.

Configuration
REQ-028 SHALL with macro MDU_SIGNED_EN defined implement MULT and DIV as signed per REQ-019..022.
REQ-029 SHALL with MDU_SIGNED_EN undefined ignore op[0] (MULT acts as MULTU, DIV as DIVU) and omit sign-fixup logic; latency unchanged.

Verification (WIDTH=32)
REQ-030 SHALL cover MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001, done on edge 34 after accept.
REQ-031 SHALL cover MULT a=0xFFFFFFFD b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; without MDU_SIGNED_EN -> hi=0x00000004 lo=0xFFFFFFF1.
REQ-032 SHALL cover DIV a=0xFFFFFFF9 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-033 SHALL cover DIVU a=100 b=0 -> lo=0xFFFFFFFF hi=0x00000064 div_by_zero=1; next start clears div_by_zero.
REQ-034 SHALL cover RST=0 at CALC iteration 10 -> next cycle busy=0 hi=lo=0, no done; start and hi_we pulsed while busy -> no effect.
REQ-035 SHALL cover back-to-back start asserted in done cycle -> accepted, busy=1 next cycle, second result correct.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 HI/LO multiply/divide unit (shift-add multiply, restoring divide).
// Signed MULT/DIV and their sign fixup are built only when MDU_SIGNED_EN is defined.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} stateT;

  stateT state, nextState;

  logic [CntW-1:0]  cnt;
  logic             isDiv;
  logic             bZero;
  logic             lastStep;
  logic             accept;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] accHi;
  logic [WIDTH-1:0] accLo;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;
  logic [WIDTH-1:0] stepHi;
  logic [WIDTH-1:0] stepLo;
  logic [WIDTH-1:0] resHi;
  logic [WIDTH-1:0] resLo;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH-1:0] divDiff;
  logic             divFits;

  assign accept   = (state == IDLE) && start;
  assign lastStep = (cnt == CntW'(WIDTH - 1));

`ifdef MDU_SIGNED_EN
  logic               aNeg;
  logic               bNeg;
  logic               signA;
  logic               signB;
  logic [2*WIDTH-1:0] prodMag;
  logic [2*WIDTH-1:0] prodNeg;

  always_comb begin
    aNeg = op[0] & a[WIDTH-1];
    bNeg = op[0] & b[WIDTH-1];
    aMag = aNeg ? -a : a;
    bMag = bNeg ? -b : b;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      signA <= 1'b0;
      signB <= 1'b0;
    end else if (accept) begin
      signA <= aNeg;
      signB <= bNeg;
    end
  end

  // Quotient keeps all ones on divide-by-zero; remainder always takes the dividend's sign.
  always_comb begin
    prodMag = {accHi, accLo};
    prodNeg = -prodMag;
    resHi   = accHi;
    resLo   = accLo;
    if (isDiv) begin
      if (signA) resHi = -accHi;
      if (bZero) resLo = '1;
      else if (signA ^ signB) resLo = -accLo;
    end else if (signA ^ signB) begin
      resHi = prodNeg[2*WIDTH-1:WIDTH];
      resLo = prodNeg[WIDTH-1:0];
    end
  end
`else
  logic unusedOp;

  assign unusedOp = op[0];
  assign aMag     = a;
  assign bMag     = b;
  assign resHi    = accHi;
  assign resLo    = accLo;
`endif

  // One radix-2 step; a zero divisor naturally yields quotient all ones and remainder = dividend.
  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, bReg} : {(WIDTH+1){1'b0}});
    divShift = {accHi, accLo[WIDTH-1]};
    divFits  = (divShift >= {1'b0, bReg});
    divDiff  = divShift[WIDTH-1:0] - bReg;
    if (isDiv) begin
      stepHi = divFits ? divDiff : divShift[WIDTH-1:0];
      stepLo = {accLo[WIDTH-2:0], divFits};
    end else begin
      stepHi = mulSum[WIDTH:1];
      stepLo = {mulSum[0], accLo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = CALC;
      CALC:    if (lastStep) nextState = FIXUP;
      FIXUP:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt   <= '0;
      isDiv <= 1'b0;
      bZero <= 1'b0;
      bReg  <= '0;
      accHi <= '0;
      accLo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            isDiv <= op[1];
            bZero <= (b == '0);
            bReg  <= bMag;
            accHi <= '0;
            accLo <= aMag;
          end
        end
        CALC: begin
          cnt   <= cnt + CntW'(1);
          accHi <= stepHi;
          accLo <= stepLo;
        end
        default: ;
      endcase
    end
  end

  // Architectural HI/LO only change on idle MTHI/MTLO writes or in FIXUP.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == FIXUP);
      if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
        if (start) div_by_zero <= 1'b0;
      end else if (state == FIXUP) begin
        hi          <= resHi;
        lo          <= resLo;
        div_by_zero <= isDiv & bZero;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit with directed, hand-computed vectors.
// Expected values for MULT/DIV follow MDU_SIGNED_EN the same way the design build does.
module tb_mult_div_unit;

  localparam int WIDTH = 32;

`ifdef MDU_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dbz;
    int               doneCyc;
  } expT;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             hi_we = 1'b0;
  logic             lo_we = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  expT sb[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got time %0t, expected < 100000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller positions this just after a negedge; the following rising edge accepts the request.
  task automatic applyStimulus(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                               input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el,
                               input logic ed, input bit push);
    expT e;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge CLK);
    #1;
    start = 1'b0;
    // done is raised by the (WIDTH+1)th edge after acceptance, so the (WIDTH+2)th edge samples it
    e.hi      = eh;
    e.lo      = el;
    e.dbz     = ed;
    e.doneCyc = cyc + WIDTH + 1;
    if (push) sb.push_back(e);
    checkOutput("busyAfterAccept", {63'd0, busy}, 64'd1);
    checkOutput("dbzClearedOnAccept", {63'd0, div_by_zero}, 64'd0);
  endtask

  task automatic waitDone();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < WIDTH + 8 && !seen; i++) begin
      @(negedge CLK);
      seen = done;
    end
    checkOutput("doneTimeout", {63'd0, seen}, 64'd1);
  endtask

  always @(negedge CLK) begin : monitor
    expT e;
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedDone: got done=1 at cycle %0d, expected no pending operation", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("resultHi", {32'd0, hi}, {32'd0, e.hi});
        checkOutput("resultLo", {32'd0, lo}, {32'd0, e.lo});
        checkOutput("resultDbz", {63'd0, div_by_zero}, {63'd0, e.dbz});
        checkOutput("doneLatency", 64'(cyc), 64'(e.doneCyc));
        checkOutput("busyInDoneCycle", {63'd0, busy}, 64'd0);
      end
    end
  end

  initial begin
    repeat (2) @(negedge CLK);
    checkOutput("resetBusy", {63'd0, busy}, 64'd0);
    checkOutput("resetDone", {63'd0, done}, 64'd0);
    checkOutput("resetDbz", {63'd0, div_by_zero}, 64'd0);
    checkOutput("resetHi", {32'd0, hi}, 64'd0);
    checkOutput("resetLo", {32'd0, lo}, 64'd0);
    RST = 1'b1;

    @(negedge CLK);
    hi_we = 1'b1;
    wdata = 32'hDEADBEEF;
    @(negedge CLK);
    hi_we = 1'b0;
    checkOutput("mthi", {32'd0, hi}, 64'hDEADBEEF);
    lo_we = 1'b1;
    wdata = 32'h0BADF00D;
    @(negedge CLK);
    lo_we = 1'b0;
    checkOutput("mtlo", {32'd0, lo}, 64'h0BADF00D);
    checkOutput("mtloKeepsHi", {32'd0, hi}, 64'hDEADBEEF);

    @(negedge CLK);
    applyStimulus(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1);
    waitDone();

    @(negedge CLK);
    applyStimulus(2'b01, 32'hFFFFFFFD, 32'd5,
                  SignedEn ? 32'hFFFFFFFF : 32'h00000004, 32'hFFFFFFF1, 1'b0, 1'b1);
    waitDone();

    @(negedge CLK);
    applyStimulus(2'b11, 32'hFFFFFFF9, 32'd2,
                  SignedEn ? 32'hFFFFFFFF : 32'h00000001,
                  SignedEn ? 32'hFFFFFFFD : 32'h7FFFFFFC, 1'b0, 1'b1);
    waitDone();

    @(negedge CLK);
    applyStimulus(2'b11, 32'h80000000, 32'hFFFFFFFF,
                  SignedEn ? 32'h00000000 : 32'h80000000,
                  SignedEn ? 32'h80000000 : 32'h00000000, 1'b0, 1'b1);
    waitDone();

    @(negedge CLK);
    applyStimulus(2'b11, 32'd7, 32'hFFFFFFFE,
                  SignedEn ? 32'h00000001 : 32'h00000007,
                  SignedEn ? 32'hFFFFFFFD : 32'h00000000, 1'b0, 1'b1);
    waitDone();

    @(negedge CLK);
    applyStimulus(2'b10, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, 1'b1, 1'b1);
    waitDone();
    @(negedge CLK);
    checkOutput("dbzHeldIdle", {63'd0, div_by_zero}, 64'd1);

    applyStimulus(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
    waitDone();
    // Request issued inside the done cycle so the next edge accepts it back-to-back
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  SignedEn ? 32'h00000000 : 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1);
    waitDone();

    @(negedge CLK);
    applyStimulus(2'b11, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b1);
    waitDone();

    @(negedge CLK);
    hi_we = 1'b1;
    wdata = 32'h55AA55AA;
    applyStimulus(2'b00, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, 1'b0, 1'b1);
    hi_we = 1'b0;
    checkOutput("writeWithStart", {32'd0, hi}, 64'h55AA55AA);
    repeat (3) @(negedge CLK);
    start = 1'b1;
    op    = 2'b10;
    a     = 32'd1;
    b     = 32'd1;
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h0;
    @(negedge CLK);
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    checkOutput("busyIgnoresHiWe", {32'd0, hi}, 64'h55AA55AA);
    checkOutput("busyIgnoresLoWe", {32'd0, lo}, 64'hFFFFFFFF);
    waitDone();

    @(negedge CLK);
    applyStimulus(2'b00, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0, 1'b0);
    repeat (10) @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    checkOutput("abortBusy", {63'd0, busy}, 64'd0);
    checkOutput("abortDone", {63'd0, done}, 64'd0);
    checkOutput("abortHi", {32'd0, hi}, 64'd0);
    checkOutput("abortLo", {32'd0, lo}, 64'd0);
    repeat (WIDTH + 4) @(negedge CLK);

    checkOutput("scoreboardDrained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
